// File: rtl/tile_scheduler.sv
// Walks an M x P result matrix in TILE_M x TILE_P tiles (raster order), issuing one
// multiply and one writeback per tile and reporting the tile geometry to both units.
module tile_scheduler #(
  parameter int TILE_M = 8,
  parameter int TILE_P = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] M,
  input  logic [15:0] N,
  input  logic [15:0] P,
  output logic        busy,
  output logic        done,
  output logic        submulti_start,
  output logic [7:0]  sub_M,
  output logic [7:0]  sub_P,
  output logic [15:0] subFM_addr,
  output logic [15:0] subFM_incr,
  output logic [15:0] subWM_addr,
  output logic [15:0] subWM_incr,
  input  logic        submulti_finish,
  output logic        store_start,
  output logic [15:0] store_row_base,
  output logic [15:0] store_col_base,
  input  logic        store_done,
  output logic [15:0] tile_cnt
);

  typedef enum logic [2:0] {
    IDLE, LOAD, ISSUE, CWAIT, STORE, SWAIT, NEXT, DONE
  } state_t;

  localparam logic [15:0] TM16 = 16'(TILE_M);
  localparam logic [15:0] TP16 = 16'(TILE_P);
  localparam logic [7:0]  TM8  = 8'(TILE_M);
  localparam logic [7:0]  TP8  = 8'(TILE_P);

  state_t      state_reg, state_next;
  logic [15:0] m_reg, n_reg, p_reg;
  logic [15:0] row_base_reg, row_base_next;
  logic [15:0] col_base_reg, col_base_next;
  logic [15:0] fm_addr_reg, fm_addr_next;
  logic [15:0] wm_addr_reg, wm_addr_next;
  logic [7:0]  sub_m_reg, sub_m_next;
  logic [7:0]  sub_p_reg, sub_p_next;
  logic [15:0] tile_cnt_reg;
  logic [15:0] rem_m, rem_p;
  logic        last_col, last_row;

  // Tile position is tracked incrementally (bases step by tile size, addresses by N),
  // so no multipliers are needed; 17-bit compares avoid wrap near 2^16.
  always_comb begin
    state_next    = state_reg;
    row_base_next = row_base_reg;
    col_base_next = col_base_reg;
    fm_addr_next  = fm_addr_reg;
    wm_addr_next  = wm_addr_reg;
    last_col      = (17'(col_base_reg) + 17'(TILE_P)) >= 17'(p_reg);
    last_row      = (17'(row_base_reg) + 17'(TILE_M)) >= 17'(m_reg);

    case (state_reg)
      IDLE:  if (start) state_next = LOAD;
      LOAD:  state_next = (m_reg == '0 || n_reg == '0 || p_reg == '0) ? DONE : ISSUE;
      ISSUE: state_next = CWAIT;
      CWAIT: if (submulti_finish) state_next = STORE;
      STORE: state_next = SWAIT;
      SWAIT: if (store_done) state_next = NEXT;
      NEXT: begin
        if (last_col) begin
          col_base_next = '0;
          wm_addr_next  = '0;
          row_base_next = row_base_reg + TM16;
          fm_addr_next  = fm_addr_reg + n_reg;
          state_next    = last_row ? DONE : ISSUE;
        end else begin
          col_base_next = col_base_reg + TP16;
          wm_addr_next  = wm_addr_reg + n_reg;
          state_next    = ISSUE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    rem_m      = m_reg - row_base_next;
    rem_p      = p_reg - col_base_next;
    sub_m_next = (rem_m > TM16) ? TM8 : rem_m[7:0];
    sub_p_next = (rem_p > TP16) ? TP8 : rem_p[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      m_reg        <= '0;
      n_reg        <= '0;
      p_reg        <= '0;
      row_base_reg <= '0;
      col_base_reg <= '0;
      fm_addr_reg  <= '0;
      wm_addr_reg  <= '0;
      sub_m_reg    <= '0;
      sub_p_reg    <= '0;
      tile_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        m_reg        <= M;
        n_reg        <= N;
        p_reg        <= P;
        row_base_reg <= '0;
        col_base_reg <= '0;
        fm_addr_reg  <= '0;
        wm_addr_reg  <= '0;
        sub_m_reg    <= '0;
        sub_p_reg    <= '0;
        tile_cnt_reg <= '0;
      end
      // Tile registers only move on entry to ISSUE, so they hold steady until SWAIT ends.
      if (state_next == ISSUE) begin
        row_base_reg <= row_base_next;
        col_base_reg <= col_base_next;
        fm_addr_reg  <= fm_addr_next;
        wm_addr_reg  <= wm_addr_next;
        sub_m_reg    <= sub_m_next;
        sub_p_reg    <= sub_p_next;
      end
      if (state_reg == NEXT) tile_cnt_reg <= tile_cnt_reg + 16'd1;
    end
  end

  assign busy           = (state_reg != IDLE);
  assign done           = (state_reg == DONE);
  assign submulti_start = (state_reg == ISSUE);
  assign store_start    = (state_reg == STORE);
  assign sub_M          = sub_m_reg;
  assign sub_P          = sub_p_reg;
  assign subFM_addr     = fm_addr_reg;
  assign subWM_addr     = wm_addr_reg;
  assign subFM_incr     = busy ? 16'd1 : 16'd0;
  assign subWM_incr     = busy ? 16'd1 : 16'd0;
  assign store_row_base = row_base_reg;
  assign store_col_base = col_base_reg;
  assign tile_cnt       = tile_cnt_reg;

endmodule

// File: tb/tb_tile_scheduler.sv
// Bench for tile_scheduler: a raster-order reference model feeds a tile queue that is
// popped on every submulti_start, plus a table of jobs and a few hand-built corner cases.
module tb_tile_scheduler;

  localparam int TM = 8;
  localparam int TP = 16;
  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        rst, start, submulti_finish, store_done;
  logic [15:0] M, N, P;
  logic        busy, done, submulti_start, store_start;
  logic [7:0]  sub_M, sub_P;
  logic [15:0] subFM_addr, subFM_incr, subWM_addr, subWM_incr;
  logic [15:0] store_row_base, store_col_base, tile_cnt;

  tile_scheduler #(.TILE_M(TM), .TILE_P(TP)) dut (
    .clk(clk), .rst(rst), .start(start), .M(M), .N(N), .P(P),
    .busy(busy), .done(done), .submulti_start(submulti_start),
    .sub_M(sub_M), .sub_P(sub_P),
    .subFM_addr(subFM_addr), .subFM_incr(subFM_incr),
    .subWM_addr(subWM_addr), .subWM_incr(subWM_incr),
    .submulti_finish(submulti_finish), .store_start(store_start),
    .store_row_base(store_row_base), .store_col_base(store_col_base),
    .store_done(store_done), .tile_cnt(tile_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  sm;
    logic [7:0]  sp;
    logic [15:0] fm;
    logic [15:0] wm;
    logic [15:0] rb;
    logic [15:0] cb;
  } tile_t;

  typedef struct {
    logic [15:0] m, n, p;
    int          cnt;
    tile_t       last;
  } vec_t;

  tile_t exp_q[$];
  tile_t last_tile;
  int    total = 0;
  int    bad = 0;
  int    cyc, n_issue, n_store, n_done, first_lat, done_lat;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input int m, input int n, input int p);
    tile_t t;
    if (m == 0 || n == 0 || p == 0) return;
    for (int mi = 0; mi * TM < m; mi++)
      for (int pi = 0; pi * TP < p; pi++) begin
        t.sm = 8'((m - mi * TM) < TM ? (m - mi * TM) : TM);
        t.sp = 8'((p - pi * TP) < TP ? (p - pi * TP) : TP);
        t.fm = 16'(mi * n);
        t.wm = 16'(pi * n);
        t.rb = 16'(mi * TM);
        t.cb = 16'(pi * TP);
        exp_q.push_back(t);
      end
  endfunction

  function automatic logic [131:0] all_outs();
    return {busy, done, submulti_start, store_start, sub_M, sub_P, subFM_addr, subFM_incr,
            subWM_addr, subWM_incr, store_row_base, store_col_base, tile_cnt};
  endfunction

  task automatic observe();
    tile_t cur, e;
    if (submulti_start) begin
      n_issue++;
      if (n_issue == 1) first_lat = cyc;
      cur = {sub_M, sub_P, subFM_addr, subWM_addr, store_row_base, store_col_base};
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tile_extra: got tile %0h expected none", cur);
      end else begin
        e = exp_q.pop_front();
        $display("tile %0d: sub %0d x %0d fm=%0d wm=%0d base=(%0d,%0d)",
                 n_issue, sub_M, sub_P, subFM_addr, subWM_addr, store_row_base, store_col_base);
        check("tile", 160'(cur), 160'(e));
        check("incr", {subFM_incr, subWM_incr}, {16'd1, 16'd1});
      end
      last_tile = cur;
    end
    if (store_start) n_store++;
    if (done) begin
      n_done++;
      if (n_done == 1) done_lat = cyc;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    observe();
  endtask

  // Drives one job to completion acting as both the multiply and writeback units.
  task automatic run_job(input int m, input int n, input int p, input int maxd,
                         input bit disturb, input int rst_tile);
    int  exp_tiles, d;
    bit  aborted;
    exp_q.delete();
    model(m, n, p);
    exp_tiles = exp_q.size();
    n_issue = 0; n_store = 0; n_done = 0; first_lat = -1; done_lat = -1;
    aborted = 1'b0;
    M = 16'(m); N = 16'(n); P = 16'(p);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    M = 16'hFFFF; N = 16'h1234; P = 16'hFFFF;
    cyc = 0;
    observe();
    while (n_done == 0 && cyc < BUDGET && !aborted) begin
      if (submulti_start) begin
        step();
        if (n_issue == rst_tile) begin
          rst = 1'b1;
          step();
          rst = 1'b0;
          aborted = 1'b1;
        end else begin
          if (disturb) begin
            start = 1'b1; M = 16'd1; N = 16'd1; P = 16'd1;
            step();
            start = 1'b0;
          end
          d = (maxd == 0) ? 0 : int'($urandom_range(maxd, 0));
          repeat (d) step();
          submulti_finish = 1'b1;
          step();
          submulti_finish = 1'b0;
        end
      end else if (store_start) begin
        step();
        if (disturb) begin
          submulti_finish = 1'b1;
          step();
          submulti_finish = 1'b0;
        end
        d = (maxd == 0) ? 0 : int'($urandom_range(maxd, 0));
        repeat (d) step();
        store_done = 1'b1;
        step();
        store_done = 1'b0;
      end else begin
        step();
      end
    end
    if (aborted) begin
      check("rst_outs", 160'(all_outs()), 160'd0);
      $display("job %0dx%0dx%0d: reset during tile %0d", m, n, p, rst_tile);
      exp_q.delete();
      return;
    end
    if (cyc >= BUDGET) begin
      total++;
      bad++;
      $display("FAIL timeout: got no done after %0d cycles expected done", cyc);
    end
    check("tile_cnt", 160'(tile_cnt), 160'(exp_tiles));
    check("issues", 160'(n_issue), 160'(exp_tiles));
    check("stores", 160'(n_store), 160'(exp_tiles));
    check("queue_left", 160'(exp_q.size()), 160'd0);
    repeat (3) step();
    check("done_once", 160'(n_done), 160'd1);
    check("idle_after", {busy, done}, 160'd0);
    $display("job %0dx%0dx%0d: tiles=%0d done_lat=%0d", m, n, p, n_issue, done_lat);
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{16'd8,  16'd4,     16'd16, 1, {8'd8, 8'd16, 16'd0,     16'd0, 16'd0,  16'd0}};
    tbl[1] = '{16'd20, 16'd3,     16'd40, 9, {8'd4, 8'd8,  16'd6,     16'd6, 16'd16, 16'd32}};
    tbl[2] = '{16'd0,  16'd4,     16'd16, 0, '0};
    tbl[3] = '{16'd8,  16'd0,     16'd16, 0, '0};
    tbl[4] = '{16'd8,  16'd4,     16'd0,  0, '0};
    tbl[5] = '{16'd9,  16'd2,     16'd17, 4, {8'd1, 8'd1,  16'd2,     16'd2, 16'd8,  16'd16}};
    tbl[6] = '{16'd1,  16'd1,     16'd1,  1, {8'd1, 8'd1,  16'd0,     16'd0, 16'd0,  16'd0}};
    tbl[7] = '{16'd16, 16'd7,     16'd32, 4, {8'd8, 8'd16, 16'd7,     16'd7, 16'd8,  16'd16}};
    tbl[8] = '{16'd24, 16'd40000, 16'd16, 3, {8'd8, 8'd16, 16'd14464, 16'd0, 16'd16, 16'd0}};

    rst = 1'b1; start = 1'b0; submulti_finish = 1'b0; store_done = 1'b0;
    M = '0; N = '0; P = '0;
    cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_outs", 160'(all_outs()), 160'd0);

    for (int i = 0; i < 9; i++) begin
      run_job(int'(tbl[i].m), int'(tbl[i].n), int'(tbl[i].p), (i % 2 == 1) ? 3 : 0, 1'b0, 0);
      check("tbl_cnt", 160'(n_issue), 160'(tbl[i].cnt));
      if (tbl[i].cnt == 0) begin
        check("zero_done_lat", 160'(done_lat), 160'd1);
      end else begin
        check("first_issue_lat", 160'(first_lat), 160'd1);
        check("tbl_last_tile", 160'(last_tile), 160'(tbl[i].last));
      end
    end

    // Stray start in CWAIT and stray finish in SWAIT must not disturb the job.
    run_job(20, 3, 40, 4, 1'b1, 0);
    check("disturb_last", 160'(last_tile), 160'({8'd4, 8'd8, 16'd6, 16'd6, 16'd16, 16'd32}));

    // Reset in CWAIT of tile 2, then a clean job from tile (0,0).
    run_job(20, 3, 40, 2, 1'b0, 2);
    check("rst_issues", 160'(n_issue), 160'd2);
    run_job(20, 3, 40, 0, 1'b0, 0);
    check("after_rst_last", 160'(last_tile), 160'({8'd4, 8'd8, 16'd6, 16'd6, 16'd16, 16'd32}));

    for (int j = 0; j < 8; j++) begin
      run_job(int'($urandom_range(40, 1)), int'($urandom_range(20, 1)),
              int'($urandom_range(40, 1)), 20, 1'b0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tile_scheduler.md
TILE_SCHEDULER -- requirements
Module: tile_scheduler

Interface
REQ-001 Parameter TILE_M, default 8, max sub-result rows per tile.
REQ-002 Parameter TILE_P, default 16, max sub-result columns per tile.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 start  in  1  one-cycle pulse requesting a full M x N x P multiply.
REQ-006 M, N, P  in  16 each  matrix dimensions; sampled only when start is accepted.
REQ-007 busy  out  1  high from accept through the DONE cycle.
REQ-008 done  out  1  one-cycle pulse at job end.
REQ-009 submulti_start  out  1  one-cycle pulse to the multiply controller.
REQ-010 sub_M, sub_P  out  8 each  current tile size.
REQ-011 subFM_addr, subFM_incr, subWM_addr, subWM_incr  out  16 each  current tile memory walk.
REQ-012 submulti_finish  in  1  tile-compute-complete pulse.
REQ-013 store_start  out  1  one-cycle pulse to the result writeback unit.
REQ-014 store_row_base, store_col_base  out  16 each  top-left element of the current tile.
REQ-015 store_done  in  1  writeback-complete pulse.
REQ-016 tile_cnt  out  16  tiles completed in the current job.

Function
REQ-017 States: IDLE, LOAD, ISSUE, CWAIT, STORE, SWAIT, NEXT, DONE; one-hot or binary at implementer's choice.
REQ-018 IDLE -> LOAD when start=1; M/N/P latched, tile_cnt cleared, tile indices mi=pi=0.
REQ-019 LOAD -> DONE if any latched dimension is 0 (no tile issued); else -> ISSUE.
REQ-020 ISSUE: submulti_start=1 for exactly this cycle; -> CWAIT unconditionally.
REQ-021 CWAIT -> STORE on submulti_finish=1; otherwise hold; no timeout.
REQ-022 STORE: store_start=1 for exactly this cycle; -> SWAIT.
REQ-023 SWAIT -> NEXT on store_done=1; otherwise hold.
REQ-024 NEXT: tile_cnt+1; pi+1, wrapping to 0 with mi+1 when (pi+1)*TILE_P >= P; -> DONE if mi wrapped past last row tile, else -> ISSUE.
REQ-025 Tile order: row tiles outer, column tiles inner (raster order).
REQ-026 DONE: done=1 for exactly this cycle; -> IDLE.
REQ-027 sub_M = min(TILE_M, M - mi*TILE_M); sub_P = min(TILE_P, P - pi*TILE_P).
REQ-028 subFM_addr = mi*N, subWM_addr = pi*N, subFM_incr = subWM_incr = 1; products truncated mod 2^16.
REQ-029 store_row_base = mi*TILE_M, store_col_base = pi*TILE_P, truncated to 16 bits.
REQ-030 All tile outputs are registered, valid from the ISSUE cycle, and stable through SWAIT.
REQ-031 start is ignored unless state is IDLE.
REQ-032 submulti_finish is ignored outside CWAIT; store_done is ignored outside SWAIT.
REQ-033 A submulti_finish and store_done asserted in the same cycle act only per REQ-032.
REQ-034 Latency: start accepted at edge k gives submulti_start high in the cycle after edge k+1.
REQ-035 busy = (state != IDLE).

Reset
REQ-036 rst=1 at an edge forces IDLE regardless of state, including mid-CWAIT/SWAIT.
REQ-037 Reset values: all outputs and internal counters are 0.
REQ-038 No pulse output is asserted in the cycle following a reset edge.

Verification
REQ-039 M=8,N=4,P=16, single finish/done -> one tile: sub_M=8, sub_P=16, addrs 0/0, incr 1/1; then done; tile_cnt=1.
REQ-040 M=20,N=3,P=40 -> 9 tiles, in order sub_M 8,8,4 by sub_P 16,16,8; tile (2,2): subFM_addr=6, subWM_addr=6, row/col base 16/32; tile_cnt=9.
REQ-041 M=0 (and separately P=0, N=0) -> done two cycles after start; no submulti_start or store_start.
REQ-042 start pulsed during CWAIT, and submulti_finish pulsed during SWAIT -> no effect on state, outputs or tile order.
REQ-043 rst during CWAIT of tile 2 -> next cycle IDLE, all outputs 0; a new start runs a clean job from tile (0,0).
REQ-044 Random 0-20 cycle delays on finish/store_done, M,P in 1..40 -> tile sequence matches the reference model; exactly one done per job.
